io_uart_leds_mmio: RTL
======================

// Module: io_uart_leds_mmio
// PURPOSE
//  Memory-mapped IO peripheral on the processor IO bus: parametrised LED register plus a
//  buffered 8N1 UART transmitter with status/control register. Replaces the unbuffered
//  LED/UART glue: software pushes bytes into a FIFO without polling busy per byte.
//  Word address = i_IO_MEM_addr[13:2]; each register is selected by one one-hot bit of it.
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  core clock frequency
//  BAUD_RATE     1_000_000   UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer, >=2)
//  FIFO_DEPTH    16          TX FIFO entries; power of 2, 2..128
//  LEDS          8           LED register width, 1..32
//  LEDS_BIT      0           word-address bit selecting LED register
//  DAT_BIT       1           word-address bit selecting UART data (W)
//  CNTL_BIT      2           word-address bit selecting UART status/control (R/W)
// PORTS
//  i_clk           in   1     clock
//  i_nrst          in   1     reset; one clock; reset is asynchronous and active-low
//  i_IO_MEM_addr   in   32    byte address from processor
//  i_IO_MEM_wdata  in   32    write data
//  i_IO_MEM_wr     in   1     write strobe, one cycle per write
//  o_IO_MEM_rdata  out  32    read data, combinational from address
//  o_leds          out  LEDS  LED register
//  o_uart_tx       out  1     serial line, idle high
// BEHAVIOUR
//  - Reset (async, i_nrst=0): o_leds=0, o_uart_tx=1, FIFO empty, pointers 0, overflow=0,
//    FSM=IDLE, counters 0. Mid-frame reset aborts the frame; line high immediately.
//  - Select sel_X = wordaddr[X_BIT]. Multiple bits set: every selected register acts.
//  - LED: wr & sel_LEDS -> o_leds <= wdata[LEDS-1:0] at that edge. Read: zero-extended o_leds.
//  - DAT write: wr & sel_DAT pushes wdata[7:0]. Accepted if count<FIFO_DEPTH or pop same
//    cycle; otherwise byte dropped, sticky overflow<=1. DAT reads return 0.
//  - CNTL read: [10]=overflow, [9]=busy (FSM!=IDLE or count!=0), [8]=full, [7:0]=count;
//    other bits 0. CNTL write with wdata[10]=1 clears overflow; a set from a dropped
//    push in the same cycle wins.
//  - rdata = OR of selected registers' read values; no select -> 0.
//  - FIFO: wr/rd pointers wrap mod FIFO_DEPTH; count 0..FIFO_DEPTH; order preserved.
//  - TX FSM IDLE->START->DATA->STOP->IDLE, bit counter CLKS_PER_BIT cycles per bit:
//    IDLE: count!=0 -> pop head into shifter, go START; o_uart_tx=0 from that edge.
//    START: 1 bit time low. DATA: 8 bits LSB first, 1 bit time each. STOP: 1 bit time high.
//    Then IDLE for exactly 1 cycle before next START. Frame = 10*CLKS_PER_BIT cycles.
//  - Latency: push at edge N into empty FIFO while IDLE -> pop at N+1, start bit from N+1.
//  - o_uart_tx is registered (glitch-free).
// TESTING
//  1 Reset: hold i_nrst=0 -> o_uart_tx=1, o_leds=0; release, read addr 0x10 -> 0.
//  2 LEDs (LEDS=8): write 0xA5 to 0x4 -> o_leds=0xA5 next cycle, read 0x4 = 0xA5;
//    write 0xFF to 0x8 -> o_leds unchanged.
//  3 Single byte (CLK 4 MHz, BAUD 1 MHz, CLKS_PER_BIT=4): write 0x55 to 0x8 -> tx low
//    4 cycles, then 1,0,1,0,1,0,1,0 4 cycles each, high 4; CNTL[9]=1 during, 0 after.
//  4 Burst (FIFO_DEPTH=4): 6 back-to-back writes 0x10..0x15 while idle -> first five
//    sent in order, 0x15 dropped, CNTL[10]=1, CNTL[8]=1 after write 6; 1 idle cycle between frames.
//  5 Overflow clear: after 4, write 0x400 to 0x10 -> CNTL[10]=0, FIFO/TX unaffected.
//  6 Mid-frame reset: i_nrst=0 during 3rd data bit -> tx=1 same cycle; after release
//    count=0, busy=0, no further frames.

Source files
------------

// File: rtl/io_uart_leds_mmio.sv
// rtl/io_uart_leds_mmio.sv - memory-mapped LED register and FIFO-buffered 8N1 UART transmitter
module io_uart_leds_mmio #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 1_000_000,
    parameter int FIFO_DEPTH  = 16,
    parameter int LEDS        = 8,
    parameter int LEDS_BIT    = 0,
    parameter int DAT_BIT     = 1,
    parameter int CNTL_BIT    = 2
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic [31:0]     i_IO_MEM_addr,
    input  logic [31:0]     i_IO_MEM_wdata,
    input  logic            i_IO_MEM_wr,
    output logic [31:0]     o_IO_MEM_rdata,
    output logic [LEDS-1:0] o_leds,
    output logic            o_uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CCW          = $clog2(CLKS_PER_BIT);
    localparam logic [CCW-1:0] CLK_LAST = CCW'(CLKS_PER_BIT - 1);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Register selects come straight from the word address (byte address bits shifted by 2).
    logic sel_leds, sel_dat, sel_cntl;
    assign sel_leds = i_IO_MEM_addr[LEDS_BIT + 2];
    assign sel_dat  = i_IO_MEM_addr[DAT_BIT + 2];
    assign sel_cntl = i_IO_MEM_addr[CNTL_BIT + 2];

    logic unused_ok;
    assign unused_ok = ^{i_IO_MEM_addr, i_IO_MEM_wdata};

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic          push_req, push_ok, pop;

    tx_state_t     state, state_n;
    logic [CCW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shifter, shifter_n;
    logic          tx_n;

    // A full FIFO still accepts a push when the transmitter pops in the same cycle.
    assign push_req = i_IO_MEM_wr & sel_dat;
    assign push_ok  = push_req & ((count != DEPTH) | pop);

    // LED register, FIFO pointers/occupancy and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_leds   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (i_IO_MEM_wr && sel_leds)
                o_leds <= i_IO_MEM_wdata[LEDS-1:0];
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped byte sets the flag even if software clears it in the same write.
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (i_IO_MEM_wr && sel_cntl && i_IO_MEM_wdata[10])
                overflow <= 1'b0;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr] <= i_IO_MEM_wdata[7:0];
    end

    // Transmitter state register; the serial line is registered so it never glitches.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shifter   <= '0;
            o_uart_tx <= 1'b1;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_idx_n;
            shifter   <= shifter_n;
            o_uart_tx <= tx_n;
        end
    end

    // Frame sequencing: start bit, 8 data bits LSB first, stop bit, one idle cycle.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        shifter_n = shifter;
        tx_n      = o_uart_tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shifter_n = mem[rd_ptr];
                    clk_cnt_n = '0;
                    tx_n      = 1'b0;
                    state_n   = START;
                end
            end
            START: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    tx_n      = shifter[0];
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shifter_n = {1'b0, shifter[7:1]};
                        tx_n      = shifter[1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [31:0] leds_rd, status_rd;
    logic        busy, full;
    assign busy      = (state != IDLE) || (count != '0);
    assign full      = (count == DEPTH);
    assign leds_rd   = 32'(o_leds);
    assign status_rd = {21'b0, overflow, busy, full, 8'(count)};

    // Read data is the OR of every selected register; the data port reads as zero.
    always_comb begin
        o_IO_MEM_rdata = '0;
        if (sel_leds)
            o_IO_MEM_rdata = o_IO_MEM_rdata | leds_rd;
        if (sel_cntl)
            o_IO_MEM_rdata = o_IO_MEM_rdata | status_rd;
    end

endmodule
